// File: rtl/data_cache.sv
// Direct-mapped, one-word-line, write-through/no-write-allocate data cache with a blocking miss FSM.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module data_cache #(
  parameter int SETS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
`endif
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 30 - IDX;

  typedef enum logic [1:0] {IDLE, MISS_RD, WR_THRU, RESP} state_t;

  state_t            state_q, state_d;
  logic [SETS-1:0]   valid_q;
  logic [TAGW-1:0]   tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  logic [29:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [IDX-1:0]    idx;
  logic [TAGW-1:0]   tag_in;
  logic [IDX-1:0]    lat_idx;
  logic [TAGW-1:0]   lat_tag;
  logic              hit;
  logic              store_hit;
  logic              refill;
  logic              unused_addr_lsb;

  assign idx             = addr_i[IDX+1:2];
  assign tag_in          = addr_i[31:IDX+2];
  assign lat_idx         = addr_q[IDX-1:0];
  assign lat_tag         = addr_q[29:IDX];
  assign hit             = valid_q[idx] && (tag_q[idx] == tag_in);
  assign store_hit       = (state_q == IDLE) && we_i && hit;
  assign refill          = (state_q == MISS_RD) && mem_ack_i;
  assign unused_addr_lsb = ^addr_i[1:0];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    stall_o     = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    case (state_q)
      IDLE: begin
        // A simultaneous load+store request is handled as a store.
        if (we_i) begin
          stall_o = 1'b1;
          addr_d  = addr_i[31:2];
          wdata_d = wdata_i;
          wstrb_d = wstrb_i;
          rdata_d = '0;
          state_d = WR_THRU;
        end else if (re_i) begin
          if (hit) begin
            rdata_o = data_q[idx];
          end else begin
            stall_o = 1'b1;
            addr_d  = addr_i[31:2];
            state_d = MISS_RD;
          end
        end
      end
      MISS_RD: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_q, 2'b00};
        if (mem_ack_i) begin
          rdata_d = mem_rdata_i;
          state_d = RESP;
        end
      end
      WR_THRU: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {addr_q, 2'b00};
        mem_wdata_o = wdata_q;
        mem_wstrb_o = wstrb_q;
        if (mem_ack_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // rdata_q is zeroed on the store path, so stores return 0 here.
        rdata_o = rdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      if (refill) begin
        valid_q[lat_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (refill) begin
        tag_q[lat_idx]  <= lat_tag;
        data_q[lat_idx] <= mem_rdata_i;
      end else if (store_hit) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb_i[b]) begin
            data_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        ld_hit, ld_miss;

  assign ld_hit  = (state_q == IDLE) && re_i && !we_i && hit;
  assign ld_miss = (state_q == IDLE) && re_i && !we_i && !hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (ld_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (ld_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter SETS, default 256, number of one-word direct-mapped lines (power of two, >=2); IDX=log2(SETS).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports re_i / we_i  input  1 each  pipeline memory-stage load / store request.
REQ-005 SHALL have ports addr_i  input  32  byte address (bits [1:0] ignored), wdata_i  input  32, wstrb_i  input  4  store byte enables.
REQ-006 SHALL have ports rdata_o  output  32  load data, stall_o  output  1  drives hazard-unit CacheStall.
REQ-007 SHALL have ports mem_req_o  output  1, mem_we_o  output  1, mem_addr_o  output  32, mem_wdata_o  output  32, mem_wstrb_o  output  4  backing-memory request.
REQ-008 SHALL have ports mem_ack_i  input  1, mem_rdata_i  input  32  backing-memory response.

Function
REQ-009 SHALL decode index=addr[IDX+1:2], tag=addr[31:IDX+2]; hit = valid[index] && tag match.
REQ-010 SHALL implement FSM states IDLE, MISS_RD, WR_THRU, RESP.
REQ-011 In IDLE with re_i && hit: rdata_o = line data same cycle, stall_o=0, stay IDLE.
REQ-012 In IDLE with re_i && miss: stall_o=1 same cycle, latch addr, go MISS_RD.
REQ-013 In IDLE with we_i (hit or miss): stall_o=1 same cycle, latch addr/wdata/wstrb, go WR_THRU; on hit, merge wdata bytes per wstrb into line at that edge; miss SHALL NOT allocate.
REQ-014 re_i && we_i together SHALL be treated as a store.
REQ-015 MISS_RD: mem_req_o=1, mem_we_o=0, mem_addr_o=latched word address, held stable until mem_ack_i; on ack write line (valid=1, tag, mem_rdata_i), capture data, go RESP; stall_o=1 throughout.
REQ-016 WR_THRU: mem_req_o=1, mem_we_o=1, latched addr/wdata/wstrb held stable until mem_ack_i; on ack go RESP; stall_o=1 throughout.
REQ-017 RESP: stall_o=0 for exactly one cycle, rdata_o = captured refill data (loads), then IDLE; request inputs SHALL NOT be re-evaluated in RESP.
REQ-018 Read-miss latency: miss cycle + N ack-wait cycles + 1 RESP cycle; hit latency 0 extra cycles.
REQ-019 rdata_o SHALL be 0 whenever no load hit/response is being returned.
REQ-020 mem_ack_i in IDLE or RESP SHALL be ignored; mem_req_o SHALL deassert the cycle after ack.
REQ-021 mem_wdata_o/mem_wstrb_o SHALL be 0 when mem_we_o=0.

Reset
REQ-022 rst SHALL clear all valid bits, force IDLE, and drive stall_o=0, mem_req_o=0, mem_we_o=0, rdata_o=0, mem_* buses 0 in the cycle following reset.
REQ-023 rst mid-MISS_RD/WR_THRU SHALL abandon the transaction without writing the line; a late ack after reset SHALL be ignored.
REQ-024 Tag/data arrays need not be reset.

Configuration
REQ-025 Macro DCACHE_STATS_EN defined: SHALL add outputs hit_count_o and miss_count_o (32 bits each), reset to 0, incrementing once per IDLE read hit / read miss, saturating at 0xFFFFFFFF; stores not counted.
REQ-026 Macro undefined: counters and ports SHALL be absent; all other behaviour identical.

Verification
REQ-027 After reset, load 0x0000_0040 with mem ack after 3 cycles returning 0xDEADBEEF -> stall_o high 4 cycles, RESP rdata_o=0xDEADBEEF, exactly one memory read.
REQ-028 Repeat load 0x0000_0040 -> stall_o=0, rdata_o=0xDEADBEEF same cycle, mem_req_o stays 0.
REQ-029 Store 0x0000_0040 wdata=0x000000AA wstrb=0001, then load 0x40 -> write-through with mem_wstrb_o=0001, subsequent hit returns 0xDEADBEAA.
REQ-030 Load 0x0000_0440 (same index, SETS=256, different tag) -> miss, refill replaces line; load 0x40 then misses.
REQ-031 rst asserted during MISS_RD, ack arrives next cycle -> state IDLE, stall_o=0, load 0x40 misses again.
REQ-032 With DCACHE_STATS_EN, sequence miss, hit, hit, store -> hit_count_o=2, miss_count_o=1.
